// File: rtl/pattern_player.sv
// Pattern store and playback engine: symbols are appended one at a time, then replayed
// forward or reversed onto a one-hot LED bus with on/gap timing and a busy/done handshake.
module pattern_player #(
  parameter int unsigned SYM_W      = 3,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned ON_CYCLES  = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [SYM_W-1:0]      push_sym,
  input  logic                  start,
  input  logic                  reverse,
  output logic [LEN_W-1:0]      len,
  output logic                  full,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<SYM_W)-1:0] led,
  output logic [LEN_W-1:0]      cur_idx
);

  localparam int unsigned LED_W   = 1 << SYM_W;
  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP, S_DONE} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cur_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rev_q;
  logic             busy_q;
  logic             done_q;
  logic [LED_W-1:0] led_q;
  logic [SYM_W-1:0] mem_q [MAX_LEN];

  logic             push_ok;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] start_idx;
  logic [LEN_W-1:0] step_idx;
  logic             at_last;

  function automatic logic [LED_W-1:0] onehot(input logic [SYM_W-1:0] s);
    onehot = LED_W'(1) << s;
  endfunction

  assign full      = (len_q == LEN_W'(MAX_LEN));
  assign push_ok   = push && !clr && !full && (state_q == S_IDLE);
  assign last_idx  = len_q - LEN_W'(1);
  assign start_idx = reverse ? last_idx : '0;
  assign step_idx  = rev_q ? (cur_idx_q - LEN_W'(1)) : (cur_idx_q + LEN_W'(1));
  assign at_last   = rev_q ? (cur_idx_q == '0) : (cur_idx_q == last_idx);

  // Symbol array; only entries below len_q are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[IDX_W'(len_q)] <= push_sym;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      rev_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= '0;
    end else if (clr) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (push_ok) begin
            len_q <= len_q + LEN_W'(1);
          end else if (start && !push) begin
            if (len_q != '0) begin
              state_q   <= S_ON;
              rev_q     <= reverse;
              cur_idx_q <= start_idx;
              cnt_q     <= CNT_W'(ON_CYCLES - 1);
              busy_q    <= 1'b1;
              led_q     <= onehot(mem_q[IDX_W'(start_idx)]);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            cnt_q   <= CNT_W'(GAP_CYCLES - 1);
            led_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (at_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_ON;
            cur_idx_q <= step_idx;
            cnt_q     <= CNT_W'(ON_CYCLES - 1);
            led_q     <= onehot(mem_q[IDX_W'(step_idx)]);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          cur_idx_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign len     = len_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign led     = led_q;
  assign cur_idx = cur_idx_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player with default parameters.
module tb_pattern_player;

  localparam int unsigned SYM_W = 3;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned ON_C = 8;
  localparam int unsigned GAP_C = 4;
  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             clk_en = 1'b1;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             push = 1'b0;
  logic [SYM_W-1:0] push_sym = '0;
  logic             start = 1'b0;
  logic             reverse = 1'b0;
  logic [LEN_W-1:0] len;
  logic             full;
  logic             busy;
  logic             done;
  logic [7:0]       led;
  logic [LEN_W-1:0] cur_idx;

  int checks = 0;
  int failures = 0;
  logic [SYM_W-1:0] exp_sym [MAX_LEN];

  pattern_player #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_C), .GAP_CYCLES(GAP_C), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_sym(push_sym),
    .start(start), .reverse(reverse), .len(len), .full(full), .busy(busy),
    .done(done), .led(led), .cur_idx(cur_idx)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] oh(input logic [SYM_W-1:0] s);
    logic [7:0] one;
    one = 8'd1;
    return one << s;
  endfunction

  task automatic do_push(input logic [SYM_W-1:0] s);
    push = 1'b1;
    push_sym = s;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Start playback and check every cycle of the busy window plus the done pulse.
  task automatic play(input int n, input logic rev, input logic disturb);
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len0;
    len0 = len;
    start = 1'b1;
    reverse = rev;
    @(negedge clk);
    start = 1'b0;
    reverse = ~rev;
    for (int i = 0; i < n; i++) begin
      idx = rev ? LEN_W'(n - 1 - i) : LEN_W'(i);
      for (int c = 0; c < int'(ON_C); c++) begin
        chk("on", 32'({busy, cur_idx, led}), 32'({1'b1, idx, oh(exp_sym[idx[4:0]])}));
        if (disturb && i == 0 && c == 2) begin
          push = 1'b1; push_sym = 3'd1; start = 1'b1;
        end else if (disturb && i == 0 && c == 3) begin
          push = 1'b0; start = 1'b0;
        end
        @(negedge clk);
      end
      for (int c = 0; c < int'(GAP_C); c++) begin
        chk("gap", 32'({busy, cur_idx, led}), 32'({1'b1, idx, 8'h00}));
        @(negedge clk);
      end
    end
    chk("done_pulse", 32'({busy, done, led}), 32'({1'b0, 1'b1, 8'h00}));
    @(negedge clk);
    chk("after_done", 32'({busy, done, cur_idx, led}), 32'(0));
    chk("len_kept", 32'(len), 32'(len0));
    reverse = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_outs", 32'({len, full, busy, done, led, cur_idx}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Forward then reverse replay of 5,2,7, with a push/start injected mid-ON
    exp_sym[0] = 3'd5; exp_sym[1] = 3'd2; exp_sym[2] = 3'd7;
    do_push(3'd5); do_push(3'd2); do_push(3'd7);
    chk("len3", 32'({full, len}), 32'({1'b0, 6'd3}));
    chk("first_led_hand", 32'(oh(exp_sym[0])), 32'h20);
    play(3, 1'b0, 1'b1);
    play(3, 1'b1, 1'b0);

    // Fill to MAX_LEN, overflow push ignored
    do_clr();
    chk("clr_len", 32'(len), 32'(0));
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      exp_sym[i] = SYM_W'((i * 3 + 1) % 8);
      do_push(exp_sym[i]);
    end
    chk("full", 32'({full, len}), 32'({1'b1, 6'd32}));
    do_push(3'd6);
    chk("full_hold", 32'({full, len}), 32'({1'b1, 6'd32}));
    play(int'(MAX_LEN), 1'b0, 1'b0);

    // Start with an empty store: done with no busy
    do_clr();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", 32'({busy, done, led}), 32'({1'b0, 1'b1, 8'h00}));
    @(negedge clk);
    chk("empty_after", 32'({busy, done, led}), 32'(0));

    // clr mid-ON
    exp_sym[0] = 3'd5; exp_sym[1] = 3'd2; exp_sym[2] = 3'd7;
    do_push(3'd5); do_push(3'd2); do_push(3'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_clr_on", 32'({busy, led}), 32'({1'b1, 8'h20}));
    do_clr();
    chk("clr_mid", 32'({busy, done, led, len, cur_idx}), 32'(0));
    @(negedge clk);
    chk("clr_no_done", 32'({busy, done}), 32'(0));

    // Async reset mid-GAP with the clock stopped
    do_push(3'd5); do_push(3'd2); do_push(3'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (ON_C + 1) @(negedge clk);
    chk("in_gap", 32'({busy, cur_idx, led}), 32'({1'b1, 6'd0, 8'h00}));
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({busy, done, led, len, cur_idx}), 32'(0));
    #3 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    @(negedge clk);
    exp_sym[0] = 3'd3; exp_sym[1] = 3'd6;
    do_push(3'd3); do_push(3'd6);
    chk("len_after_rst", 32'(len), 32'(2));
    play(2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
